// File: rtl/ser_pkg.sv
// Shared definitions for the bit serializer: FSM encoding, default idle
// level and the sizing helper for the per-word bit counter.
package ser_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  localparam logic IDLE_LEVEL_DEF = 1'b1;

  // Width of a counter that must hold WIDTH-1 (at least one bit).
  function automatic int bit_cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder: one shifter plus a one-word holding buffer so
// consecutive words leave on j without an idle bit between them.
module bit_serializer
  import ser_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   MSB_FIRST  = 1,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF,
  parameter int   CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             j,
  output logic             j_valid,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent,
  output state_t           dbg_state
);

  localparam int             BCW      = bit_cnt_w(WIDTH);
  localparam logic [BCW-1:0] LAST_IDX = BCW'(WIDTH - 1);

  // Handshake: a word transfers at a rising edge where din_valid && din_ready.
  // din_ready depends only on the buffer flag, never on din_valid, and drops
  // while a word is parked in the buffer so it can never be overwritten.

  state_t             r_state;
  logic [WIDTH-1:0]   r_shift;
  logic [WIDTH-1:0]   r_buf;
  logic               r_buf_full;
  logic [BCW-1:0]     r_bit_cnt;
  logic               r_j;
  logic [CNT_W-1:0]   r_words;

  logic [WIDTH-1:0]   w_shifted;
  logic               w_hs;

  function automatic logic first_bit(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
  endfunction

  always_comb begin
    w_shifted = r_shift;
    if (MSB_FIRST != 0) w_shifted = r_shift << 1;
    else                w_shifted = r_shift >> 1;
  end

  assign w_hs = din_valid && !r_buf_full;

  // r_j always holds the bit on the line this cycle, so loads and shifts
  // precompute the head of the word that will be in the shifter next.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_bit_cnt  <= '0;
      r_j        <= IDLE_LEVEL;
      r_words    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_j        <= IDLE_LEVEL;
          r_buf_full <= 1'b0;
          if (w_hs) begin
            r_shift   <= din;
            r_j       <= first_bit(din);
            r_bit_cnt <= LAST_IDX;
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (r_bit_cnt != '0) begin
            r_shift   <= w_shifted;
            r_j       <= first_bit(w_shifted);
            r_bit_cnt <= r_bit_cnt - BCW'(1);
            if (w_hs) begin
              r_buf      <= din;
              r_buf_full <= 1'b1;
            end
          end else begin
            // Last bit on the line: chain the next word in with no gap.
            r_words   <= r_words + CNT_W'(1);
            r_bit_cnt <= LAST_IDX;
            if (r_buf_full) begin
              r_shift    <= r_buf;
              r_j        <= first_bit(r_buf);
              r_buf_full <= 1'b0;
            end else if (w_hs) begin
              r_shift <= din;
              r_j     <= first_bit(din);
            end else begin
              r_state <= S_IDLE;
              r_j     <= IDLE_LEVEL;
            end
          end
        end
      endcase
    end
  end

  assign din_ready  = !r_buf_full;
  assign j          = r_j;
  assign j_valid    = (r_state == S_SHIFT);
  assign busy       = (r_state == S_SHIFT) || r_buf_full;
  assign words_sent = r_words;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: MSB-first 8-bit instance, an LSB-first instance
// and a 2-bit-counter instance share one stimulus stream.
module tb_bit_serializer;
  import ser_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;

  logic       din_ready, j, j_valid, busy;
  logic [7:0] words_sent;
  state_t     dbg_state;

  logic       l_ready, l_j, l_j_valid, l_busy;
  logic [7:0] l_words;
  state_t     l_state;

  logic       c_ready, c_j, c_j_valid, c_busy;
  logic [1:0] c_words;
  state_t     c_state;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(1'b1), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .j(j), .j_valid(j_valid), .busy(busy), .words_sent(words_sent), .dbg_state(dbg_state)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_LEVEL(1'b1), .CNT_W(8)) dut_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(l_ready),
    .j(l_j), .j_valid(l_j_valid), .busy(l_busy), .words_sent(l_words), .dbg_state(l_state)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(1'b1), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(c_ready),
    .j(c_j), .j_valid(c_j_valid), .busy(c_busy), .words_sent(c_words), .dbg_state(c_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus table ----------------
  // exp_msb / exp_lsb: expected line order, first transmitted bit in [7].
  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_msb;
    logic [7:0] exp_lsb;
  } vec_t;

  vec_t vecs[8];

  // ---------------- scoreboard ----------------
  logic exp_q[$];
  logic lsb_q[$];
  int   exp_words;
  int   bit_idx;
  int   run_len;
  int   max_run;
  bit   rdy_low_seen;
  bit   chk_en;
  int   total;
  int   bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("j_valid",    32'(j_valid),    32'(exp_q.size() != 0));
      check("busy",       32'(busy),       32'(exp_q.size() != 0));
      check("state",      32'(dbg_state == S_SHIFT), 32'(exp_q.size() != 0));
      check("din_ready",  32'(din_ready),  32'(exp_q.size() <= 8));
      check("words_sent", 32'(words_sent), 32'(exp_words[7:0]));
      check("c2_words",   32'(c_words),    32'(exp_words[1:0]));
      if (!din_ready) rdy_low_seen = 1'b1;
      if (exp_q.size() != 0) begin
        check("j_bit",   32'(j),   32'(exp_q.pop_front()));
        check("lsb_bit", 32'(l_j), 32'(lsb_q.pop_front()));
        run_len++;
        bit_idx++;
        if (bit_idx == 8) begin
          bit_idx = 0;
          exp_words++;
        end
      end else begin
        check("j_idle",   32'(j),   32'h1);
        check("lsb_idle", 32'(l_j), 32'h1);
        run_len = 0;
      end
      if (run_len > max_run) max_run = run_len;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int idx);
    logic rdy;
    bit   done;
    done      = 1'b0;
    din       = vecs[idx].din;
    din_valid = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      rdy = din_ready;
      @(posedge clk);
      if (rdy) done = 1'b1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL send_timeout: got no handshake want handshake");
    end else begin
      for (int k = 7; k >= 0; k--) begin
        exp_q.push_back(vecs[idx].exp_msb[k]);
        lsb_q.push_back(vecs[idx].exp_lsb[k]);
      end
    end
    #1;
    din_valid = 1'b0;
    din       = 8'($urandom_range(0, 255));
  endtask

  task automatic pulse_reset();
    din_valid = 1'b0;
    rst       = 1'b0;
    @(posedge clk);
    exp_q.delete();
    lsb_q.delete();
    exp_words = 0;
    bit_idx   = 0;
    #1;
    rst = 1'b1;
  endtask

  // Returns at negedge+2 of the cycle carrying the last expected bit.
  task automatic wait_drain();
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0) break;
    end
    check("drain_left", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic realign();
    @(posedge clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int gap;
    vecs[0] = '{8'h7C, 8'h7C, 8'h3E};
    vecs[1] = '{8'hFF, 8'hFF, 8'hFF};
    vecs[2] = '{8'h01, 8'h01, 8'h80};
    vecs[3] = '{8'hA5, 8'hA5, 8'hA5};
    vecs[4] = '{8'h12, 8'h12, 8'h48};
    vecs[5] = '{8'h80, 8'h80, 8'h01};
    vecs[6] = '{8'h5E, 8'h5E, 8'h7A};
    vecs[7] = '{8'h0F, 8'h0F, 8'hF0};

    total = 0; bad = 0; exp_words = 0; bit_idx = 0;
    run_len = 0; max_run = 0; rdy_low_seen = 1'b0; chk_en = 1'b0;
    rst = 1'b0; din = '0; din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b1;
    chk_en = 1'b1;

    @(negedge clk);
    check("rst_j",      32'(j),          32'h1);
    check("rst_jvalid", 32'(j_valid),    32'h0);
    check("rst_ready",  32'(din_ready),  32'h1);
    check("rst_words",  32'(words_sent), 32'h0);
    realign();

    // Reset in the middle of a word discards it.
    send(3);
    repeat (3) @(posedge clk);
    #1;
    pulse_reset();
    @(negedge clk);
    check("midrst_j",      32'(j),          32'h1);
    check("midrst_jvalid", 32'(j_valid),    32'h0);
    check("midrst_busy",   32'(busy),       32'h0);
    check("midrst_ready",  32'(din_ready),  32'h1);
    check("midrst_words",  32'(words_sent), 32'h0);
    realign();

    // Single word.
    max_run = 0;
    send(0);
    wait_drain();
    @(negedge clk);
    check("single_j",      32'(j),          32'h1);
    check("single_jvalid", 32'(j_valid),    32'h0);
    check("single_words",  32'(words_sent), 32'h1);
    check("single_run",    32'(max_run),    32'd8);
    realign();

    // Back-to-back with din_valid held: second word parks in the buffer.
    max_run = 0;
    send(0);
    send(1);
    @(negedge clk);
    check("b2b_ready_low", 32'(din_ready), 32'h0);
    wait_drain();
    @(negedge clk);
    check("b2b_run",   32'(max_run),    32'd16);
    check("b2b_words", 32'(words_sent), 32'd3);
    realign();

    // Second handshake lands exactly on the last-bit cycle.
    max_run = 0;
    rdy_low_seen = 1'b0;
    send(2);
    repeat (7) @(posedge clk);
    #1;
    send(5);
    wait_drain();
    @(negedge clk);
    check("direct_run",      32'(max_run),      32'd16);
    check("direct_buf_used", 32'(rdy_low_seen), 32'h0);
    check("direct_words",    32'(words_sent),   32'd5);
    realign();

    // More words with random gaps; the 2-bit counter wraps along the way.
    for (int i = 0; i < 4; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) @(posedge clk);
      if (gap != 0) #1;
      send((i == 3) ? 0 : i + 4);
    end
    wait_drain();
    @(negedge clk);
    check("wrap_words",  32'(words_sent), 32'd9);
    check("wrap_c2",     32'(c_words),    32'd1);
    check("wrap_busy",   32'(c_busy),     32'h0);
    repeat (3) @(negedge clk);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Upstream feeder for the serial pattern detector: accepts parallel words over a valid/ready handshake and emits them one bit per clock on serial line j.
- A one-word holding buffer lets back-to-back words go out with no idle gap.
- Between words the line is driven to a fixed idle level, so the detector sees a defined quiet stream.
- Also provides a per-bit strobe, a busy flag and a sent-word counter for the surrounding control logic.

Parameters:
WIDTH, 8, bits per input word (2..32)
MSB_FIRST, 1, 1 = shift out din[WIDTH-1] first; 0 = din[0] first
IDLE_LEVEL, 1'b1, value driven on j when no word is in flight
CNT_W, 8, width of the sent-word counter

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  reset, synchronous, active-low: sampled on rising clk, rst==0 resets
din  input  WIDTH  parallel word to transmit
din_valid  input  1  din holds a valid word
din_ready  output  1  block can accept a word this cycle
j  output  1  serial bit stream (registered)
j_valid  output  1  high in every cycle j carries a data bit
busy  output  1  word in shifter or buffer
words_sent  output  CNT_W  count of fully transmitted words, wraps

Behaviour:
- Reset (rst==0 at posedge) has priority over everything, including mid-word:
  - outputs: j=IDLE_LEVEL, j_valid=0, busy=0, words_sent=0;
  - shifter and buffer marked empty, partial words discarded;
  - din_ready=1 from the first cycle after reset.
- Handshake: a word is accepted when din_valid && din_ready at a rising edge. din_ready = !buf_full, combinational from a register, never from din_valid.
- FSM states (shared package): S_IDLE, S_SHIFT.
- S_IDLE:
  - j=IDLE_LEVEL, j_valid=0, buffer always empty.
  - On handshake: load the shifter, set bit_cnt=WIDTH-1, go to S_SHIFT.
- S_SHIFT:
  - Each cycle j = current bit, j_valid=1, then shift by one and decrement bit_cnt.
  - Latency: a handshake at edge T puts the first bit on j during T..T+1; bit k appears in cycle T+1+k.
- Handshake while shifting and not on the last bit (bit_cnt!=0): the word goes to the buffer and buf_full is set.
- Last-bit cycle (bit_cnt==0), resolved at its closing edge:
  - buf_full → shifter loads the buffer, buf_full clears, stay in S_SHIFT (no gap);
  - else handshake this cycle → word loads the shifter directly, buffer stays empty, stay in S_SHIFT (no gap);
  - else → S_IDLE; j returns to IDLE_LEVEL in the next cycle.
- A buffered word cannot be overwritten: din_ready=0 while buf_full, so buffer load and a new handshake never coincide.
- words_sent increments by 1 at the closing edge of every last-bit cycle and wraps modulo 2^CNT_W.
- busy = (state==S_SHIFT) || buf_full.
- j_valid==1 exactly when state==S_SHIFT.
- din is sampled only at the handshake edge; later changes on din have no effect.

Decomposition:
- Shared package (ser_pkg): state encoding S_IDLE/S_SHIFT, default IDLE_LEVEL constant, and a function for the bit_cnt width, $clog2(WIDTH).
- No sub-module: buffer, shifter and FSM fit in one module of about 150 lines.

Test Plan:
- Reset mid-word: load 8'hA5, after 3 bits drive rst=0 for one edge → next cycle j=1, j_valid=0, busy=0, din_ready=1, words_sent=0.
- Single word (MSB_FIRST=1): din=8'h7C with handshake at edge T:
  - j = 0,1,1,1,1,1,0,0 in cycles T+1..T+8, j_valid=1 throughout;
  - cycle T+9: j=1, j_valid=0, words_sent=1;
  - with the detector attached, w=1 after the seventh bit.
- Back-to-back: 8'h7C then 8'hFF, din_valid held high → 16 consecutive j_valid=1 cycles, no idle bit between words; din_ready=0 from acceptance of 8'hFF until 8'hFF moves to the shifter; words_sent=2 at the end.
- Direct load on last bit: second handshake exactly in the last-bit cycle of word 1 with buffer empty → word 2 bit 0 follows with no gap; buf_full never set.
- LSB_FIRST (MSB_FIRST=0): din=8'h01 → j = 1,0,0,0,0,0,0,0.
- Counter wrap (CNT_W=2): send 5 words → words_sent = 1,2,3,0,1 after each completes; busy low only after the last bit.
